// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the framebuffer write scheduler.
//   FB_WORDS / FB_AW      : framebuffer size in 32-bit words and address width
//   REG_*                 : control-register offsets (address[1:0] when address[15]=1)
//   CTRL_*_BIT            : bit positions inside the self-clearing CTRL register
//   fill_state_t          : fill-engine FSM states
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_WORDS = 9600;
  localparam int FB_AW    = 15;

  localparam logic [1:0] REG_FILL_START   = 2'd0;
  localparam logic [1:0] REG_FILL_COUNT   = 2'd1;
  localparam logic [1:0] REG_FILL_PATTERN = 2'd2;
  localparam logic [1:0] REG_CTRL         = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fb_fill_engine.sv
// ---------------------------------------------------------------------------
// fb_fill_engine
// Holds the fill control registers and runs the IDLE/FILL state machine that
// walks a block of framebuffer words, writing one pattern word per granted slot.
// Ports:
//   clk50, reset        : clock, asynchronous active-high reset
//   reg_wr, reg_sel     : control-register write strobe and register offset
//   reg_wdata           : control-register write data
//   fill_grant          : write port granted to the fill this cycle
//   fill_req            : fill wants the write port this cycle
//   fill_addr           : word address the fill writes when granted
//   fill_pattern        : FILL_PATTERN register (data written by the fill)
//   busy                : fill in progress
//   done                : one-cycle pulse when a fill completes
// ---------------------------------------------------------------------------
module fb_fill_engine #(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int FB_AW    = fb_pkg::FB_AW
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             reg_wr,
  input  logic [1:0]       reg_sel,
  input  logic [31:0]      reg_wdata,
  input  logic             fill_grant,
  output logic             fill_req,
  output logic [FB_AW-1:0] fill_addr,
  output logic [31:0]      fill_pattern,
  output logic             busy,
  output logic             done
);

  import fb_pkg::*;

  localparam logic [31:0]      WORDS     = 32'(FB_WORDS);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_WORDS - 1);

  fill_state_t      state;
  logic [FB_AW-1:0] fill_start;
  logic [FB_AW-1:0] fill_count;
  logic [FB_AW-1:0] remaining;
  logic [FB_AW-1:0] start_mod;
  logic             ctrl_wr;
  logic             start_now;
  logic             abort_now;

  assign ctrl_wr   = reg_wr && (reg_sel == REG_CTRL);
  assign start_now = ctrl_wr && reg_wdata[CTRL_START_BIT];
  assign abort_now = ctrl_wr && reg_wdata[CTRL_ABORT_BIT];

  // Out-of-range start addresses are folded back into the framebuffer.
  assign start_mod = FB_AW'(32'(fill_start) % WORDS);

  // An abort arriving this cycle withdraws the request so no further word
  // is written once the CPU has asked the fill to stop.
  assign fill_req = (state == S_FILL) && !abort_now;

  // Fill FSM. The working address/count are separate from the programmed
  // registers so FILL_START/FILL_COUNT keep their values across fills.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fill_start   <= '0;
      fill_count   <= '0;
      fill_pattern <= '0;
      fill_addr    <= '0;
      remaining    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Register writes are only honoured while idle.
          if (reg_wr) begin
            case (reg_sel)
              REG_FILL_START:   fill_start   <= reg_wdata[FB_AW-1:0];
              REG_FILL_COUNT:   fill_count   <= reg_wdata[FB_AW-1:0];
              REG_FILL_PATTERN: fill_pattern <= reg_wdata;
              default:          ;
            endcase
          end
          if (start_now) begin
            if (fill_count != '0) begin
              state     <= S_FILL;
              busy      <= 1'b1;
              fill_addr <= start_mod;
              remaining <= fill_count;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (abort_now) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fill_grant) begin
            fill_addr <= (fill_addr == LAST_ADDR) ? '0 : fill_addr + FB_AW'(1);
            remaining <= remaining - FB_AW'(1);
            if (remaining == FB_AW'(1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// ---------------------------------------------------------------------------
// fb_write_sched
// Avalon slave that shares one framebuffer write port between CPU word writes
// and a hardware fill engine, using round-robin arbitration on contention.
// Ports:
//   clk50, reset        : clock, asynchronous active-high reset
//   chipselect, write   : Avalon slave select and write strobe
//   address[15:0]       : bit 15 = 0 framebuffer word, bit 15 = 1 control reg
//   writedata[31:0]     : Avalon write data
//   waitrequest         : stalls a CPU framebuffer write that lost arbitration
//   fb_wren             : framebuffer write enable (registered)
//   fb_wraddress        : framebuffer word address (registered)
//   fb_data             : framebuffer write data (registered)
//   busy, done          : fill engine status
// ---------------------------------------------------------------------------
module fb_write_sched #(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int FB_AW    = fb_pkg::FB_AW
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic [15:0]      address,
  input  logic [31:0]      writedata,
  output logic             waitrequest,
  output logic             fb_wren,
  output logic [FB_AW-1:0] fb_wraddress,
  output logic [31:0]      fb_data,
  output logic             busy,
  output logic             done
);

  import fb_pkg::*;

  localparam logic [31:0] WORDS = 32'(FB_WORDS);

  logic             cpu_access;
  logic             cpu_fb_hit;
  logic             cpu_in_range;
  logic             cpu_pend;
  logic             reg_wr;
  logic             fill_req;
  logic             grant_cpu;
  logic             grant_fill;
  logic             last_grant_fill;
  logic [FB_AW-1:0] fill_addr;
  logic [31:0]      fill_pattern;

  assign cpu_access   = chipselect && write;
  assign cpu_fb_hit   = cpu_access && !address[15];
  assign cpu_in_range = {17'b0, address[14:0]} < WORDS;
  // Out-of-range framebuffer writes never compete for the port; they are
  // acknowledged immediately and dropped.
  assign cpu_pend     = cpu_fb_hit && cpu_in_range;
  assign reg_wr       = cpu_access && address[15];

  fb_fill_engine #(
    .FB_WORDS (FB_WORDS),
    .FB_AW    (FB_AW)
  ) u_fill (
    .clk50        (clk50),
    .reset        (reset),
    .reg_wr       (reg_wr),
    .reg_sel      (address[1:0]),
    .reg_wdata    (writedata),
    .fill_grant   (grant_fill),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .fill_pattern (fill_pattern),
    .busy         (busy),
    .done         (done)
  );

  // Round-robin arbiter: on a tie the side that did not win last time wins.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_fill = 1'b0;
    if (cpu_pend && fill_req) begin
      if (last_grant_fill) grant_cpu  = 1'b1;
      else                 grant_fill = 1'b1;
    end else if (cpu_pend) begin
      grant_cpu = 1'b1;
    end else if (fill_req) begin
      grant_fill = 1'b1;
    end
  end

  assign waitrequest = cpu_pend && grant_fill;

  // Registered write port. Address/data hold when nothing is granted.
  // last_grant_fill resets to 1 so the CPU wins the first tie.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      fb_wren         <= 1'b0;
      fb_wraddress    <= '0;
      fb_data         <= '0;
      last_grant_fill <= 1'b1;
    end else begin
      fb_wren <= grant_cpu || grant_fill;
      if (grant_cpu) begin
        fb_wraddress    <= address[FB_AW-1:0];
        fb_data         <= writedata;
        last_grant_fill <= 1'b0;
      end else if (grant_fill) begin
        fb_wraddress    <= fill_addr;
        fb_data         <= fill_pattern;
        last_grant_fill <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// ---------------------------------------------------------------------------
// tb_fb_write_sched
// Directed self-checking bench for fb_write_sched: reset state, plain fills,
// address wrap, CPU/fill contention, zero-count start, abort, reset mid-fill,
// pattern writes while busy and out-of-range CPU writes.
// ---------------------------------------------------------------------------
module tb_fb_write_sched;

  localparam int FB_WORDS = 9600;
  localparam int FB_AW    = 15;

  localparam logic [15:0] A_START   = 16'h8000;
  localparam logic [15:0] A_COUNT   = 16'h8001;
  localparam logic [15:0] A_PATTERN = 16'h8002;
  localparam logic [15:0] A_CTRL    = 16'h8003;

  logic             clk50 = 1'b0;
  logic             reset;
  logic             chipselect;
  logic             write;
  logic [15:0]      address;
  logic [31:0]      writedata;
  logic             waitrequest;
  logic             fb_wren;
  logic [FB_AW-1:0] fb_wraddress;
  logic [31:0]      fb_data;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          done_count;
  int          busy_cycles;

  fb_write_sched #(
    .FB_WORDS (FB_WORDS),
    .FB_AW    (FB_AW)
  ) dut (
    .clk50        (clk50),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .fb_wren      (fb_wren),
    .fb_wraddress (fb_wraddress),
    .fb_data      (fb_data),
    .busy         (busy),
    .done         (done)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) cyc++;

  // Record every framebuffer write and status pulse mid-cycle.
  always @(negedge clk50) begin
    if (fb_wren) begin
      log_addr.push_back(int'(fb_wraddress));
      log_data.push_back(fb_data);
      log_cyc.push_back(cyc);
    end
    if (done) done_count++;
    if (busy) busy_cycles++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_obs();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    done_count  = 0;
    busy_cycles = 0;
  endtask

  // Present one Avalon write and hold it while waitrequest is high.
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, output int waits);
    logic stalled;
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    waits      = 0;
    forever begin
      @(negedge clk50);
      stalled = waitrequest;
      @(posedge clk50);
      if (!stalled) break;
      waits++;
      if (waits > 20) break;
    end
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wait_fill_end(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk50);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk50);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    repeat (2) @(posedge clk50);
    #1;
    checks++; if (fb_wren !== 1'b0)   begin errors++; $display("[TB] FAIL reset_fb_wren: got %0b want 0", fb_wren); end
    checks++; if (fb_wraddress !== '0) begin errors++; $display("[TB] FAIL reset_fb_wraddress: got %0d want 0", fb_wraddress); end
    checks++; if (fb_data !== '0)      begin errors++; $display("[TB] FAIL reset_fb_data: got %h want 0", fb_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL reset_waitrequest: got %0b want 0", waitrequest); end
    reset = 1'b0;
    @(posedge clk50);
    #1;
  endtask

  task automatic test_basic_fill();
    int w;
    bit ok;
    int exp_a[4] = '{0, 1, 2, 3};
    $display("[TB] basic fill START=0 COUNT=4");
    clear_obs();
    bus_write(A_START, 32'd0, w);
    bus_write(A_COUNT, 32'd4, w);
    bus_write(A_PATTERN, 32'hFFFF_FFFF, w);
    checks++; if (w !== 0) begin errors++; $display("[TB] FAIL reg_write_wait: got %0d want 0", w); end
    bus_write(A_CTRL, 32'h1, w);
    wait_fill_end(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_timeout: busy still high"); end
    checks++; if (log_addr.size() !== 4) begin errors++; $display("[TB] FAIL basic_nwrites: got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size()) begin errors++; $display("[TB] FAIL basic_addr%0d: missing want %0d", i, exp_a[i]); end
      else if (log_addr[i] !== exp_a[i] || log_data[i] !== 32'hFFFF_FFFF || log_cyc[i] !== log_cyc[0] + i) begin
        errors++;
        $display("[TB] FAIL basic_write%0d: got addr %0d data %h cyc+%0d want addr %0d data ffffffff cyc+%0d",
                 i, log_addr[i], log_data[i], log_cyc[i] - log_cyc[0], exp_a[i], i);
      end
    end
    checks++; if (done_count !== 1)  begin errors++; $display("[TB] FAIL basic_done: got %0d pulses want 1", done_count); end
    checks++; if (busy_cycles !== 4) begin errors++; $display("[TB] FAIL basic_busy: got %0d cycles want 4", busy_cycles); end
  endtask

  task automatic test_wrap();
    int w;
    bit ok;
    int exp_a[4] = '{9598, 9599, 0, 1};
    $display("[TB] wrap START=9598 COUNT=4");
    clear_obs();
    bus_write(A_START, 32'd9598, w);
    bus_write(A_PATTERN, 32'h5A5A_0001, w);
    bus_write(A_CTRL, 32'h1, w);
    wait_fill_end(ok);
    checks++; if (log_addr.size() !== 4) begin errors++; $display("[TB] FAIL wrap_nwrites: got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size()) begin errors++; $display("[TB] FAIL wrap_addr%0d: missing want %0d", i, exp_a[i]); end
      else if (log_addr[i] !== exp_a[i]) begin errors++; $display("[TB] FAIL wrap_addr%0d: got %0d want %0d", i, log_addr[i], exp_a[i]); end
    end
    $display("[TB] modulo START=9605 COUNT=2");
    clear_obs();
    bus_write(A_START, 32'd9605, w);
    bus_write(A_COUNT, 32'd2, w);
    bus_write(A_CTRL, 32'h1, w);
    wait_fill_end(ok);
    checks++;
    if (log_addr.size() !== 2) begin errors++; $display("[TB] FAIL modulo_nwrites: got %0d want 2", log_addr.size()); end
    else if (log_addr[0] !== 5 || log_addr[1] !== 6) begin
      errors++; $display("[TB] FAIL modulo_addr: got %0d,%0d want 5,6", log_addr[0], log_addr[1]);
    end
  endtask

  task automatic test_contention();
    int w1, w2, w;
    int hits;
    bit ok;
    int          exp_a[8] = '{16, 0, 17, 1, 2, 3, 4, 5};
    logic [31:0] exp_d[8] = '{32'h10, 32'hA5A5A5A5, 32'h11, 32'hA5A5A5A5,
                              32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    $display("[TB] CPU writes during fill");
    clear_obs();
    bus_write(A_START, 32'd0, w);
    bus_write(A_COUNT, 32'd6, w);
    bus_write(A_PATTERN, 32'hA5A5_A5A5, w);
    bus_write(A_CTRL, 32'h1, w);
    bus_write(16'h0010, 32'h0000_0010, w1);
    bus_write(16'h0011, 32'h0000_0011, w2);
    wait_fill_end(ok);
    checks++; if (w1 !== 0) begin errors++; $display("[TB] FAIL cont_wait1: got %0d want 0", w1); end
    checks++; if (w2 !== 1) begin errors++; $display("[TB] FAIL cont_wait2: got %0d want 1", w2); end
    checks++; if (log_addr.size() !== 8) begin errors++; $display("[TB] FAIL cont_nwrites: got %0d want 8", log_addr.size()); end
    hits = 0;
    foreach (log_addr[i]) if (log_addr[i] == 16) hits++;
    checks++; if (hits !== 1) begin errors++; $display("[TB] FAIL cont_once: addr 0x10 written %0d times want 1", hits); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= log_addr.size()) begin errors++; $display("[TB] FAIL cont_write%0d: missing want addr %0d", i, exp_a[i]); end
      else if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL cont_write%0d: got addr %0d data %h want addr %0d data %h",
                 i, log_addr[i], log_data[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (done_count !== 1) begin errors++; $display("[TB] FAIL cont_done: got %0d want 1", done_count); end
  endtask

  task automatic test_zero_count();
    int w;
    bit ok;
    $display("[TB] zero count start");
    clear_obs();
    bus_write(A_COUNT, 32'd0, w);
    bus_write(A_CTRL, 32'h1, w);
    wait_fill_end(ok);
    checks++; if (log_addr.size() !== 0) begin errors++; $display("[TB] FAIL zero_nwrites: got %0d want 0", log_addr.size()); end
    checks++; if (done_count !== 1)      begin errors++; $display("[TB] FAIL zero_done: got %0d want 1", done_count); end
    checks++; if (busy_cycles !== 0)     begin errors++; $display("[TB] FAIL zero_busy: got %0d want 0", busy_cycles); end
  endtask

  task automatic test_abort();
    int w;
    $display("[TB] abort after two writes");
    clear_obs();
    bus_write(A_START, 32'd100, w);
    bus_write(A_COUNT, 32'd10, w);
    bus_write(A_PATTERN, 32'h1234_5678, w);
    bus_write(A_CTRL, 32'h1, w);
    repeat (2) @(posedge clk50);
    #1;
    bus_write(A_CTRL, 32'h2, w);
    repeat (6) @(posedge clk50);
    #1;
    checks++;
    if (log_addr.size() !== 2) begin errors++; $display("[TB] FAIL abort_nwrites: got %0d want 2", log_addr.size()); end
    else if (log_addr[0] !== 100 || log_addr[1] !== 101 || log_data[1] !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL abort_addr: got %0d,%0d data %h want 100,101 data 12345678", log_addr[0], log_addr[1], log_data[1]);
    end
    checks++; if (done_count !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d want 0", done_count); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL abort_busy: got %0b want 0", busy); end
    bus_write(A_CTRL, 32'h2, w);
    repeat (3) @(posedge clk50);
    #1;
    checks++;
    if (busy !== 1'b0 || done_count !== 0 || log_addr.size() !== 2) begin
      errors++; $display("[TB] FAIL abort_idle: got busy %0b done %0d writes %0d want 0 0 2", busy, done_count, log_addr.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int w;
    int n;
    $display("[TB] reset during fill");
    clear_obs();
    bus_write(A_START, 32'd0, w);
    bus_write(A_COUNT, 32'd100, w);
    bus_write(A_PATTERN, 32'hCAFE_F00D, w);
    bus_write(A_CTRL, 32'h1, w);
    repeat (5) @(posedge clk50);
    #1;
    checks++; if (fb_wren !== 1'b1) begin errors++; $display("[TB] FAIL midfill_active: fb_wren got %0b want 1", fb_wren); end
    n = log_addr.size();
    reset = 1'b1;
    #1;
    checks++;
    if (fb_wren !== 1'b0 || fb_wraddress !== '0 || fb_data !== '0 || busy !== 1'b0 || done !== 1'b0 || waitrequest !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midfill_reset: got wren %0b addr %0d data %h busy %0b done %0b wait %0b want all 0",
               fb_wren, fb_wraddress, fb_data, busy, done, waitrequest);
    end
    repeat (3) @(posedge clk50);
    #1;
    checks++; if (log_addr.size() !== n) begin errors++; $display("[TB] FAIL midfill_nowrite: got %0d writes want %0d", log_addr.size(), n); end
    reset = 1'b0;
    @(posedge clk50);
    #1;
    bus_write(16'h0020, 32'hDEAD_BEEF, w);
    repeat (2) @(posedge clk50);
    #1;
    checks++; if (w !== 0) begin errors++; $display("[TB] FAIL post_reset_wait: got %0d want 0", w); end
    checks++;
    if (log_addr.size() !== n + 1) begin errors++; $display("[TB] FAIL post_reset_nwrites: got %0d want %0d", log_addr.size(), n + 1); end
    else if (log_addr[n] !== 32 || log_data[n] !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL post_reset_write: got addr %0d data %h want 32 deadbeef", log_addr[n], log_data[n]);
    end
    checks++; if (done_count !== 0) begin errors++; $display("[TB] FAIL midfill_done: got %0d want 0", done_count); end
  endtask

  task automatic test_pattern_while_busy();
    int w;
    bit ok;
    $display("[TB] pattern write while busy");
    clear_obs();
    bus_write(A_START, 32'd50, w);
    bus_write(A_COUNT, 32'd3, w);
    bus_write(A_PATTERN, 32'h1111_1111, w);
    bus_write(A_CTRL, 32'h1, w);
    bus_write(A_PATTERN, 32'h2222_2222, w);
    checks++; if (w !== 0) begin errors++; $display("[TB] FAIL busy_reg_wait: got %0d want 0", w); end
    wait_fill_end(ok);
    checks++; if (log_addr.size() !== 3) begin errors++; $display("[TB] FAIL busy_nwrites: got %0d want 3", log_addr.size()); end
    for (int i = 0; i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 50 + i || log_data[i] !== 32'h1111_1111) begin
        errors++; $display("[TB] FAIL busy_write%0d: got addr %0d data %h want addr %0d data 11111111", i, log_addr[i], log_data[i], 50 + i);
      end
    end
    clear_obs();
    bus_write(A_CTRL, 32'h1, w);
    wait_fill_end(ok);
    checks++;
    if (log_addr.size() !== 3) begin errors++; $display("[TB] FAIL busy_refill_nwrites: got %0d want 3", log_addr.size()); end
    else if (log_data[0] !== 32'h1111_1111 || log_data[2] !== 32'h1111_1111) begin
      errors++; $display("[TB] FAIL busy_refill_data: got %h want 11111111", log_data[0]);
    end
  endtask

  task automatic test_out_of_range();
    int w1, w2, w3;
    $display("[TB] out-of-range CPU writes");
    clear_obs();
    bus_write(16'd9600, 32'hBAD0_0001, w1);
    bus_write(16'h7FFF, 32'hBAD0_0002, w2);
    repeat (3) @(posedge clk50);
    #1;
    checks++; if (w1 !== 0 || w2 !== 0) begin errors++; $display("[TB] FAIL oor_wait: got %0d,%0d want 0,0", w1, w2); end
    checks++; if (log_addr.size() !== 0) begin errors++; $display("[TB] FAIL oor_nwrites: got %0d want 0", log_addr.size()); end
    bus_write(16'd9599, 32'h0000_BEEF, w3);
    repeat (2) @(posedge clk50);
    #1;
    checks++;
    if (log_addr.size() !== 1) begin errors++; $display("[TB] FAIL last_word_nwrites: got %0d want 1", log_addr.size()); end
    else if (log_addr[0] !== 9599 || log_data[0] !== 32'h0000_BEEF) begin
      errors++; $display("[TB] FAIL last_word_write: got addr %0d data %h want 9599 0000beef", log_addr[0], log_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_wrap();
    test_contention();
    test_zero_count();
    test_abort();
    test_reset_mid_fill();
    test_pattern_while_busy();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
FB_WRITE_SCHED -- requirements
Module: fb_write_sched

Interface
REQ-001 Parameter FB_WORDS, default 9600, number of 32-bit framebuffer words (640x480 at 1 bpp).
REQ-002 Parameter FB_AW, default 15, framebuffer word-address width.
REQ-003 clk50  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 chipselect  input  1  Avalon slave select.
REQ-006 write  input  1  Avalon write strobe.
REQ-007 address  input  16  bit 15 = 0 selects framebuffer word [14:0]; bit 15 = 1 selects control register [1:0].
REQ-008 writedata  input  32  Avalon write data.
REQ-009 waitrequest  output  1  Avalon stall; the CPU holds chipselect, write, address and writedata while it is high.
REQ-010 fb_wren  output  1  framebuffer write enable.
REQ-011 fb_wraddress  output  FB_AW  framebuffer write address.
REQ-012 fb_data  output  32  framebuffer write data.
REQ-013 busy  output  1  fill engine active.
REQ-014 done  output  1  one-cycle pulse when a fill completes.

Function
REQ-015 Control registers: 0 = FILL_START[14:0], 1 = FILL_COUNT[14:0], 2 = FILL_PATTERN[31:0], 3 = CTRL (bit 0 start, bit 1 abort; self-clearing).
REQ-016 Control-register writes never assert waitrequest and complete in the cycle they are presented.
REQ-017 Writes to registers 0-2 while busy=1 are ignored, and a CTRL start while busy=1 is ignored.
REQ-018 The fill FSM has two states: IDLE and FILL; a CTRL start in IDLE with FILL_COUNT>0 enters FILL on the next edge and sets busy=1.
REQ-019 A CTRL start with FILL_COUNT=0 stays in IDLE, performs no writes, and pulses done one cycle later.
REQ-020 In FILL, each granted slot writes FILL_PATTERN to the current address, then increments the address and decrements the remaining count.
REQ-021 The fill address wraps from FB_WORDS-1 to 0, and a FILL_START >= FB_WORDS is reduced modulo FB_WORDS at start.
REQ-022 When the last word is granted, the FSM returns to IDLE, busy falls, and done pulses on the same edge.
REQ-023 A CTRL abort in FILL returns the FSM to IDLE on the next edge with no further fill writes and no done pulse; an abort in IDLE has no effect.
REQ-024 Each cycle, exactly one requester receives the write port: a pending CPU framebuffer write or the FILL engine.
REQ-025 When only one requester is pending it is granted, and when both are pending the requester not granted last time wins (round-robin).
REQ-026 waitrequest = CPU framebuffer write pending AND grant to fill (combinational).
REQ-027 Outputs fb_wren, fb_wraddress and fb_data are registered, giving one-cycle latency from grant to write.
REQ-028 fb_wren is 0 in any cycle with no grant, and fb_wraddress and fb_data hold their previous values.
REQ-029 A CPU framebuffer address >= FB_WORDS is accepted without waitrequest and discarded (fb_wren stays 0).

Reset
REQ-030 Reset asserted: FSM = IDLE; all registers, fb_wren, fb_wraddress, fb_data, busy and done = 0; the last-grant flag points to fill, so the CPU wins the first tie.
REQ-031 Reset asserted mid-fill aborts the fill immediately with no done pulse, and no write occurs while reset is high.

Structure
REQ-032 A shared package fb_pkg holds FB_WORDS, FB_AW, the register offsets, the CTRL bit positions and the fill-state enum.
REQ-033 Sub-module fb_fill_engine (FSM, address/count counters, wrap logic) is instantiated once; arbitration and output registers live in fb_write_sched.

Verification
REQ-034 START=0, COUNT=4, PATTERN=0xFFFFFFFF, then start -> fb_wren on 4 consecutive cycles at addresses 0, 1, 2, 3; done pulses once; busy is high for 4 cycles.
REQ-035 START=9598, COUNT=4 -> writes to addresses 9598, 9599, 0, 1.
REQ-036 CPU holds a write to address 0x0010 during an active fill -> grants alternate CPU/fill; waitrequest is high for at most 1 cycle per CPU write; data 0x0010 is written exactly once.
REQ-037 COUNT=0, then start -> no fb_wren and one done pulse; an abort after 2 fill writes -> no more writes and no done pulse.
REQ-038 Reset asserted mid-fill (COUNT=100) -> all outputs 0 within the same cycle; an idle CPU write after reset is granted with no waitrequest.
REQ-039 CPU writes to FILL_PATTERN while busy -> the fill continues with the old pattern, and the register still holds the old value after done.
